clk_div_ctrl: RTL

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_pkg.sv | 12 +
 rtl/clk_div_core.sv | 34 +++
 rtl/clk_div_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-divider controller.
package clk_div_pkg;

  localparam int unsigned DefaultW = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StPend = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_core.sv
// W-bit loadable down-counter that saturates at zero and flags it.
module clk_div_core #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable 50% clock divider with a valid/ready ratio handshake.
// New ratios are deferred to the next period boundary so no phase is cut short.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         out,
  output logic         tick,
  output logic         active
);

  state_e       state_q, state_d;
  logic         out_q, out_d;
  logic         tick_q, tick_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] pend_q, pend_d;
  logic         cnt_load;
  logic [W-1:0] cnt_load_val;
  logic         cnt_zero;
  logic         xfer;

  clk_div_core #(
    .W (W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q != StIdle),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  assign cfg_ready = (state_q != StPend);
  assign xfer      = cfg_valid && cfg_ready;

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    tick_d       = 1'b0;
    div_d        = div_q;
    pend_d       = pend_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;

    unique case (state_q)
      StIdle: begin
        if (xfer && (cfg_div != '0)) begin
          div_d        = cfg_div;
          cnt_load     = 1'b1;
          cnt_load_val = cfg_div - W'(1);
          state_d      = StRun;
        end
      end

      StRun: begin
        if (cnt_zero) begin
          out_d        = !out_q;
          tick_d       = !out_q;
          cnt_load     = 1'b1;
          cnt_load_val = div_q - W'(1);
        end
        if (xfer) begin
          pend_d  = cfg_div;
          state_d = StPend;
        end
      end

      StPend: begin
        if (cnt_zero) begin
          if (out_q) begin
            // High phase ends on the old ratio; pending value waits for the boundary.
            out_d        = 1'b0;
            cnt_load     = 1'b1;
            cnt_load_val = div_q - W'(1);
          end else if (pend_q != '0) begin
            div_d        = pend_q;
            cnt_load     = 1'b1;
            cnt_load_val = pend_q - W'(1);
            out_d        = 1'b1;
            tick_d       = 1'b1;
            state_d      = StRun;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
      div_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
    end
  end

  assign out    = out_q;
  assign tick   = tick_q;
  assign active = (state_q != StIdle);

endmodule
